// File: rtl/window_alu_ctrl_if.sv
// Instruction-side and decoded-output signal bundle for window_alu_ctrl.
// The master modport belongs to the instruction register side and the slave modport to the decoder.
interface window_alu_ctrl_if #(
  parameter int FUNC_W  = 8,
  parameter int NUM_WIN = 4,
  parameter int ALU_W   = 4
);
  localparam int WIN_W = $clog2(NUM_WIN);

  logic              instValid;
  logic              stall;
  logic [FUNC_W-1:0] func;
  logic [ALU_W-1:0]  aluFunc;
  logic              nop;
  logic              ldWnd;
  logic [WIN_W-1:0]  window;
  logic              winOvf;
  logic              winUnf;
  logic              illegal;

  modport master (
    output instValid, stall, func,
    input  aluFunc, nop, ldWnd, window, winOvf, winUnf, illegal
  );

  modport slave (
    input  instValid, stall, func,
    output aluFunc, nop, ldWnd, window, winOvf, winUnf, illegal
  );
endinterface

// File: rtl/window_alu_ctrl.sv
// Registered ALU function decoder with a register-window pointer (absolute select, call/return depth).
// Define WIN_FLAG_STICKY_EN to make winOvf/winUnf sticky until reset or an absolute window select.
module window_alu_ctrl #(
  parameter int FUNC_W  = 8,
  parameter int NUM_WIN = 4,
  parameter int ALU_W   = 4
) (
  input logic               clk,
  input logic               rst,
  window_alu_ctrl_if.slave  bus
);
  localparam int WIN_W = $clog2(NUM_WIN);

  localparam logic [ALU_W-1:0] ALU_MOVE = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_SUB  = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_AND  = ALU_W'(3);
  localparam logic [ALU_W-1:0] ALU_OR   = ALU_W'(4);
  localparam logic [ALU_W-1:0] ALU_NOT  = ALU_W'(5);
  localparam logic [ALU_W-1:0] ALU_NOP  = ALU_W'(6);

  localparam logic [WIN_W-1:0] MAX_DEPTH = WIN_W'(NUM_WIN - 1);
  localparam logic [6:0]       WIN_LIMIT = 7'(NUM_WIN);

  typedef enum logic [2:0] {
    OP_ALU,
    OP_NOP,
    OP_WND,
    OP_WINC,
    OP_WDEC,
    OP_ILL
  } op_e;

  op_e              op;
  logic [ALU_W-1:0] op_code;
  logic             upper_zero;

  logic [ALU_W-1:0] alu_func_q;
  logic             nop_q;
  logic             ld_wnd_q;
  logic [WIN_W-1:0] cur_win_q;
  logic [WIN_W-1:0] depth_q;
  logic             win_ovf_q;
  logic             win_unf_q;
  logic             illegal_q;

  assign upper_zero = (bus.func >> 8) == '0;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    op      = OP_ILL;
    op_code = ALU_NOP;
    if (upper_zero) begin
      case (bus.func[7:0])
        8'h01:   begin op = OP_ALU; op_code = ALU_MOVE; end
        8'h02:   begin op = OP_ALU; op_code = ALU_ADD;  end
        8'h04:   begin op = OP_ALU; op_code = ALU_SUB;  end
        8'h08:   begin op = OP_ALU; op_code = ALU_AND;  end
        8'h10:   begin op = OP_ALU; op_code = ALU_OR;   end
        8'h20:   begin op = OP_ALU; op_code = ALU_NOT;  end
        8'h40:   op = OP_NOP;
        8'hC0:   op = OP_WINC;
        8'hC1:   op = OP_WDEC;
        default: begin
          if (bus.func[7:6] == 2'b10 && {1'b0, bus.func[5:0]} < WIN_LIMIT)
            op = OP_WND;
        end
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_func_q <= ALU_NOP;
      nop_q      <= 1'b0;
      ld_wnd_q   <= 1'b0;
      cur_win_q  <= '0;
      depth_q    <= '0;
      win_ovf_q  <= 1'b0;
      win_unf_q  <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (!bus.stall) begin
      alu_func_q <= ALU_NOP;
      nop_q      <= 1'b0;
      ld_wnd_q   <= 1'b0;
      illegal_q  <= 1'b0;
`ifndef WIN_FLAG_STICKY_EN
      win_ovf_q  <= 1'b0;
      win_unf_q  <= 1'b0;
`endif
      if (bus.instValid) begin
        case (op)
          OP_ALU: begin
            alu_func_q <= op_code;
            nop_q      <= 1'b1;
          end
          OP_WND: begin
            cur_win_q <= bus.func[WIN_W-1:0];
            depth_q   <= '0;
            ld_wnd_q  <= 1'b1;
`ifdef WIN_FLAG_STICKY_EN
            win_ovf_q <= 1'b0;
            win_unf_q <= 1'b0;
`endif
          end
          OP_WINC: begin
            if (depth_q == MAX_DEPTH) begin
              win_ovf_q <= 1'b1;
            end else begin
              cur_win_q <= cur_win_q + 1'b1;
              depth_q   <= depth_q + 1'b1;
              ld_wnd_q  <= 1'b1;
            end
          end
          OP_WDEC: begin
            if (depth_q == '0) begin
              win_unf_q <= 1'b1;
            end else begin
              cur_win_q <= cur_win_q - 1'b1;
              depth_q   <= depth_q - 1'b1;
              ld_wnd_q  <= 1'b1;
            end
          end
          OP_ILL:  illegal_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign bus.aluFunc = alu_func_q;
  assign bus.nop     = nop_q;
  assign bus.ldWnd   = ld_wnd_q;
  assign bus.window  = cur_win_q;
  assign bus.winOvf  = win_ovf_q;
  assign bus.winUnf  = win_unf_q;
  assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_window_alu_ctrl.sv
// Directed-vector bench for window_alu_ctrl (FUNC_W=9, NUM_WIN=4); flag expectations follow
// whichever WIN_FLAG_STICKY_EN build is compiled.
module tb_window_alu_ctrl;
  localparam int FUNC_W  = 9;
  localparam int NUM_WIN = 4;
  localparam int ALU_W   = 4;
`ifdef WIN_FLAG_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  window_alu_ctrl_if #(.FUNC_W(FUNC_W), .NUM_WIN(NUM_WIN), .ALU_W(ALU_W)) bus ();

  window_alu_ctrl #(.FUNC_W(FUNC_W), .NUM_WIN(NUM_WIN), .ALU_W(ALU_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Apply one set of inputs for one edge, then sample 1 time unit after that edge.
  task automatic step(input logic r, input logic s, input logic v, input logic [FUNC_W-1:0] f);
    rst           = r;
    bus.stall     = s;
    bus.instValid = v;
    bus.func      = f;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input int alu, input bit nop, input bit ld,
                            input int win, input bit ovf, input bit unf, input bit ill);
    check({tag, ".aluFunc"}, 32'(bus.aluFunc), 32'(alu));
    check({tag, ".nop"},     32'(bus.nop),     32'(nop));
    check({tag, ".ldWnd"},   32'(bus.ldWnd),   32'(ld));
    check({tag, ".window"},  32'(bus.window),  32'(win));
    check({tag, ".winOvf"},  32'(bus.winOvf),  32'(ovf));
    check({tag, ".winUnf"},  32'(bus.winUnf),  32'(unf));
    check({tag, ".illegal"}, 32'(bus.illegal), 32'(ill));
  endtask

  localparam logic [FUNC_W-1:0] WINC = 9'h0C0;
  localparam logic [FUNC_W-1:0] WDEC = 9'h0C1;

  logic [FUNC_W-1:0] alu_vec [6] = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h020};
  logic [FUNC_W-1:0] ill_vec [5] = '{9'h084, 9'h003, 9'h1C0, 9'h0C2, 9'h0FF};

  initial begin
    bus.stall = 1'b0; bus.instValid = 1'b0; bus.func = '0;

    // Reset for two cycles, then an ADD
    step(1, 0, 0, 9'h000);
    step(1, 0, 0, 9'h000);
    expect_all("reset", 6, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 9'h002);
    expect_all("add", 1, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, alu_vec[i]);
      check($sformatf("alu%0d.aluFunc", i), 32'(bus.aluFunc), 32'(i));
      check($sformatf("alu%0d.nop", i), 32'(bus.nop), 32'd1);
    end
    step(0, 0, 1, 9'h040);
    expect_all("nop_op", 6, 0, 0, 0, 0, 0, 0);

    // Absolute select then call with wrap; returns down to depth 0 and underflow
    step(0, 0, 1, 9'h083);  expect_all("wnd3", 6, 0, 1, 3, 0, 0, 0);
    step(0, 0, 1, WINC);    expect_all("winc_wrap", 6, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, WINC);    expect_all("winc_d2", 6, 0, 1, 1, 0, 0, 0);
    step(0, 0, 1, WDEC);    expect_all("wdec_d1", 6, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, WDEC);    expect_all("wdec_wrap", 6, 0, 1, 3, 0, 0, 0);
    step(0, 0, 1, WDEC);    expect_all("wdec_unf0", 6, 0, 0, 3, 0, 1, 0);

    // Overflow at max depth, then return to window 0 and underflow
    step(0, 0, 1, 9'h080);  expect_all("wnd0", 6, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 1, WINC);
      check($sformatf("call%0d.window", i), 32'(bus.window), 32'(i));
      check($sformatf("call%0d.ldWnd", i), 32'(bus.ldWnd), 32'd1);
    end
    step(0, 0, 1, WINC);    expect_all("winc_ovf", 6, 0, 0, 3, 1, 0, 0);
    step(0, 0, 1, WDEC);    expect_all("ret1", 6, 0, 1, 2, STICKY, 0, 0);
    step(0, 0, 1, WDEC);    check("ret2.window", 32'(bus.window), 32'd1);
    step(0, 0, 1, WDEC);    check("ret3.window", 32'(bus.window), 32'd0);
    step(0, 0, 1, WDEC);    expect_all("wdec_unf", 6, 0, 0, 0, STICKY, 1, 0);

    // Illegal encodings leave the window alone
    step(0, 0, 1, 9'h082);  check("wnd2.window", 32'(bus.window), 32'd2);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 9'h002);
      step(0, 0, 1, ill_vec[i]);
      expect_all($sformatf("ill%0d", i), 6, 0, 0, 2, 0, 0, 1);
    end
    step(0, 0, 0, 9'h000);  expect_all("bubble_after_ill", 6, 0, 0, 2, 0, 0, 0);

    // Stall freezes outputs and the pointer
    step(0, 0, 1, WINC);    expect_all("pre_stall", 6, 0, 1, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, WINC);
      expect_all($sformatf("stall%0d", i), 6, 0, 1, 3, 0, 0, 0);
    end
    step(0, 0, 0, WINC);    expect_all("bubble", 6, 0, 0, 3, 0, 0, 0);
    step(0, 0, 1, 9'h008);
    step(0, 1, 1, 9'h040);  expect_all("stall_alu", 3, 1, 0, 3, 0, 0, 0);
    step(0, 0, 1, 9'h0C4);
    step(0, 1, 0, 9'h000);  expect_all("stall_ill", 6, 0, 0, 3, 0, 0, 1);

    // Reset wins over a simultaneous WINC and over stall
    step(1, 0, 1, WINC);    expect_all("rst_winc", 6, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, WINC);    step(0, 0, 1, 9'h002);
    step(1, 1, 1, WINC);    expect_all("rst_stall", 6, 0, 0, 0, 0, 0, 0);

    // Overflow flag lifetime and clear by absolute select
    step(0, 0, 1, WINC); step(0, 0, 1, WINC); step(0, 0, 1, WINC);
    step(0, 0, 1, WINC);    check("ovf_set", 32'(bus.winOvf), 32'd1);
    step(0, 0, 1, 9'h040);  check("ovf_after_nop", 32'(bus.winOvf), 32'(STICKY));
    step(0, 0, 1, 9'h081);  expect_all("wnd1_clear", 6, 0, 1, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
